// File: rtl/count_watch_pkg.sv
// Shared types and default constants for the count_watch monitor.
package count_watch_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 8;
  localparam int unsigned DEFAULT_WRAP_W = 4;

  localparam logic [DEFAULT_WIDTH-1:0] CNT_MAX = {DEFAULT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPend
  } state_t;

endpackage

// File: rtl/count_watch_if.sv
// Signal bundle between the counter/control side (master) and the monitor (slave).
interface count_watch_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WRAP_W = 4
);

  logic              enable;
  logic [WIDTH-1:0]  count;
  logic              arm;
  logic [WIDTH-1:0]  threshold;
  logic              irq_ack;
  logic              irq;
  logic [WIDTH-1:0]  hit_count;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_total;
  logic              overflow;

  modport master (
    output enable, count, arm, threshold, irq_ack,
    input  irq, hit_count, wrap_pulse, wrap_total, overflow
  );

  modport slave (
    input  enable, count, arm, threshold, irq_ack,
    output irq, hit_count, wrap_pulse, wrap_total, overflow
  );

endinterface

// File: rtl/count_watch_wrap_detector.sv
// Detects max->0 wrap of a running counter and keeps a wrap tally with sticky overflow.
module count_watch_wrap_detector #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              overflow
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  logic [WIDTH-1:0]  prev_q;
  logic              valid_q;
  logic              enable_q;
  logic              pulse_q;
  logic [WRAP_W-1:0] total_q;
  logic              overflow_q;
  logic              wrap_det;

  // enable_q is the enable seen on the edge that moved count from prev_q to its current value.
  assign wrap_det = valid_q && enable_q && (prev_q == MaxVal) && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      valid_q    <= 1'b0;
      enable_q   <= 1'b0;
      pulse_q    <= 1'b0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q   <= count;
      valid_q  <= 1'b1;
      enable_q <= enable;
      pulse_q  <= wrap_det;
      if (wrap_det) begin
        total_q <= total_q + 1'b1;
        if (total_q == '1) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign wrap_pulse = pulse_q;
  assign wrap_total = total_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/count_watch.sv
// Counter monitor: wrap tally plus an armed threshold-match interrupt with acknowledge.
module count_watch
  import count_watch_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned WRAP_W = DEFAULT_WRAP_W
) (
  input logic         clk,
  input logic         rst,
  count_watch_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] hit_q, hit_d;
  logic             irq_q, irq_d;

  count_watch_wrap_detector #(
    .WIDTH  (WIDTH),
    .WRAP_W (WRAP_W)
  ) u_wrap_detector (
    .clk        (clk),
    .rst        (rst),
    .enable     (bus.enable),
    .count      (bus.count),
    .wrap_pulse (bus.wrap_pulse),
    .wrap_total (bus.wrap_total),
    .overflow   (bus.overflow)
  );

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    hit_d   = hit_q;
    irq_d   = irq_q;
    unique case (state_q)
      StIdle: begin
        if (bus.arm) begin
          state_d = StArmed;
          thr_d   = bus.threshold;
        end
      end
      StArmed: begin
        // A match takes priority over a simultaneous re-arm.
        if (bus.count == thr_q) begin
          state_d = StPend;
          hit_d   = bus.count;
          irq_d   = 1'b1;
        end else if (bus.arm) begin
          thr_d = bus.threshold;
        end
      end
      StPend: begin
        if (bus.irq_ack) begin
          state_d = StIdle;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      thr_q   <= '0;
      hit_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      hit_q   <= hit_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_count_watch.sv
// Directed plus randomized bench for count_watch against a cycle-level reference model.
module tb_count_watch;
  import count_watch_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned WW = DEFAULT_WRAP_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_watch_if #(.WIDTH(W), .WRAP_W(WW)) bus ();

  count_watch #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: wraps counted as a plain integer, FSM as a mode number.
  int           n_edges;
  logic [W-1:0] m_prev;
  logic         m_prev_en;
  int           m_wraps;
  logic         m_pulse;
  int           m_mode;   // 0 idle, 1 armed, 2 pending
  logic [W-1:0] m_thr;
  logic [W-1:0] m_hit;
  logic [W-1:0] cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n_edges = 0; m_prev = '0; m_prev_en = 1'b0; m_wraps = 0; m_pulse = 1'b0;
    m_mode = 0; m_thr = '0; m_hit = '0;
  endtask

  task automatic model_edge(input logic en, input logic [W-1:0] c, input logic a,
                            input logic [W-1:0] t, input logic ack);
    m_pulse = (n_edges > 0) && m_prev_en && (m_prev == CNT_MAX) && (c == '0);
    if (m_pulse) m_wraps++;
    m_prev = c; m_prev_en = en; n_edges++;
    case (m_mode)
      0: if (a) begin m_mode = 1; m_thr = t; end
      1: if (c == m_thr) begin m_mode = 2; m_hit = c; end
         else if (a) m_thr = t;
      default: if (ack) m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("irq",        32'(bus.irq),        32'(m_mode == 2));
    chk("hit_count",  32'(bus.hit_count),  32'(m_hit));
    chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_pulse));
    chk("wrap_total", 32'(bus.wrap_total), 32'(m_wraps % (1 << WW)));
    chk("overflow",   32'(bus.overflow),   32'(m_wraps >= (1 << WW)));
  endtask

  task automatic step(input logic en, input logic [W-1:0] c, input logic a,
                      input logic [W-1:0] t, input logic ack);
    bus.enable = en; bus.count = c; bus.arm = a; bus.threshold = t; bus.irq_ack = ack;
    @(posedge clk);
    model_edge(en, c, a, t, ack);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [W-1:0] c;
    logic         en;
    logic         a;
    logic         ack;
    logic [W-1:0] t;

    bus.enable = 1'b0; bus.count = '0; bus.arm = 1'b0; bus.threshold = '0; bus.irq_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.count = W'($urandom);
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst = 1'b0;

    // First sample after reset never flags a wrap.
    step(1'b1, '0, 1'b0, '0, 1'b0);
    chk("first_sample_no_wrap", 32'(bus.wrap_pulse), 32'd0);

    // Arm at threshold 5 and run the counter up.
    step(1'b1, W'(1), 1'b1, W'(5), 1'b0);
    for (int i = 2; i <= 5; i++) step(1'b1, W'(i), 1'b0, '0, 1'b0);
    chk("irq_at_5", 32'(bus.irq), 32'd1);
    chk("hit_at_5", 32'(bus.hit_count), 32'h05);
    step(1'b1, W'(6), 1'b0, '0, 1'b0);
    step(1'b1, W'(7), 1'b0, '0, 1'b0);
    chk("irq_held", 32'(bus.irq), 32'd1);
    step(1'b1, W'(8), 1'b0, '0, 1'b1);
    chk("irq_after_ack", 32'(bus.irq), 32'd0);

    // Genuine wrap, then a counter reset from 0x80 and a wrap with enable low.
    step(1'b1, W'(8'hFE), 1'b0, '0, 1'b0);
    step(1'b1, W'(8'hFF), 1'b0, '0, 1'b0);
    step(1'b1, W'(8'h00), 1'b0, '0, 1'b0);
    chk("wrap_pulse_ff_00", 32'(bus.wrap_pulse), 32'd1);
    chk("wrap_total_one", 32'(bus.wrap_total), 32'd1);
    step(1'b1, W'(8'h80), 1'b0, '0, 1'b0);
    step(1'b1, W'(8'h00), 1'b0, '0, 1'b0);
    chk("counter_reset_no_wrap", 32'(bus.wrap_pulse), 32'd0);
    step(1'b0, W'(8'hFF), 1'b0, '0, 1'b0);
    step(1'b1, W'(8'h00), 1'b0, '0, 1'b0);
    chk("disabled_no_wrap", 32'(bus.wrap_pulse), 32'd0);

    // Back-to-back wraps up to tally rollover, then beyond.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, W'(8'hFF), 1'b0, '0, 1'b0);
      step(1'b1, W'(8'h00), 1'b0, '0, 1'b0);
    end
    chk("rollover_total", 32'(bus.wrap_total), 32'd0);
    chk("rollover_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(8'hFF), 1'b0, '0, 1'b0);
      step(1'b1, W'(8'h00), 1'b0, '0, 1'b0);
    end
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);

    // Re-arm 0x10 -> 0x20 while armed.
    step(1'b1, W'(8'h08), 1'b1, W'(8'h10), 1'b0);
    for (int i = 9; i <= 11; i++) step(1'b1, W'(i), 1'b0, '0, 1'b0);
    step(1'b1, W'(8'h0C), 1'b1, W'(8'h20), 1'b0);
    for (int i = 13; i <= 16; i++) step(1'b1, W'(i), 1'b0, '0, 1'b0);
    chk("no_irq_old_thr", 32'(bus.irq), 32'd0);
    for (int i = 17; i <= 32; i++) step(1'b1, W'(i), 1'b0, '0, 1'b0);
    chk("irq_new_thr", 32'(bus.irq), 32'd1);
    chk("hit_new_thr", 32'(bus.hit_count), 32'h20);
    // Arm while pending, and arm coincident with the ack, are both ignored.
    step(1'b1, W'(8'h21), 1'b1, W'(8'h22), 1'b0);
    step(1'b1, W'(8'h22), 1'b1, W'(8'h23), 1'b1);
    step(1'b1, W'(8'h23), 1'b0, '0, 1'b0);
    chk("arm_with_ack_ignored", 32'(bus.irq), 32'd0);

    // Randomized run: enable gaps, counter resets, arms near the count, random acks.
    cnt = W'(8'h24);
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      a   = ($urandom_range(0, 14) == 0);
      t   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(cnt + W'($urandom_range(0, 6)));
      ack = ($urandom_range(0, 3) == 0);
      step(en, cnt, a, t, ack);
      if ($urandom_range(0, 99) == 0) cnt = '0;
      else if (en) cnt = cnt + 1'b1;
    end

    // Asynchronous reset while an interrupt is pending.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, W'(8'h40), 1'b1, W'(8'h41), 1'b0);
    step(1'b1, W'(8'h41), 1'b0, '0, 1'b0);
    chk("irq_before_async_rst", 32'(bus.irq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("irq_async_clear", 32'(bus.irq), 32'd0);
    chk("hit_async_clear", 32'(bus.hit_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    c = W'(8'h41);
    step(1'b1, c, 1'b0, '0, 1'b0);
    chk("idle_after_rst", 32'(bus.irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
